// File: rtl/glycemic_pkg.sv
// Shared types and default parameters for the glycemic index monitor.
package glycemic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } gi_state_t;

    typedef enum logic {
        DIR_HIGH = 1'b0,
        DIR_LOW  = 1'b1
    } alarm_dir_t;

    localparam int DEF_SENSOR_W = 8;
    localparam int DEF_GI_W     = 4;
    localparam int DEF_WIN_LOG2 = 2;
    localparam int DEF_HI_TH    = 12;
    localparam int DEF_LO_TH    = 3;
    localparam int DEF_HYST     = 1;
    localparam int DEF_CONFIRM  = 2;

endpackage

// File: rtl/gi_alarm_tracker.sv
// Debounced alarm with hysteresis: raises after CONFIRM consecutive qualifying
// windows, releases only once the index moves HYST steps past the threshold.
module gi_alarm_tracker
    import glycemic_pkg::*;
#(
    parameter alarm_dir_t DIR     = DIR_HIGH,
    parameter int         GI_W    = DEF_GI_W,
    parameter int         TH      = DEF_HI_TH,
    parameter int         HYST    = DEF_HYST,
    parameter int         CONFIRM = DEF_CONFIRM
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_update,
    input  logic [GI_W-1:0] i_index,
    output logic            o_alarm
);

    localparam int CNT_W = $clog2(CONFIRM + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_alarm;
    int               w_idx;
    logic             w_qualify;
    logic             w_release;

    always_comb begin
        w_idx     = int'(i_index);
        w_qualify = 1'b0;
        w_release = 1'b0;
        if (DIR == DIR_HIGH) begin
            w_qualify = (w_idx >= TH);
            w_release = (w_idx < TH - HYST);
        end else begin
            w_qualify = (w_idx <= TH);
            w_release = (w_idx > TH + HYST);
        end
    end

    // Counter saturates at CONFIRM so a long qualifying run cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_alarm <= 1'b0;
        end else if (i_update) begin
            if (w_qualify) begin
                if (int'(r_cnt) < CONFIRM) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (int'(r_cnt) + 1 >= CONFIRM) begin
                    r_alarm <= 1'b1;
                end
            end else begin
                r_cnt <= '0;
                if (w_release) begin
                    r_alarm <= 1'b0;
                end
            end
        end
    end

    assign o_alarm = r_alarm;

endmodule

// File: rtl/glycemic_index_monitor.sv
// Windowed averaging of blood-sensor samples into a glycemic index with
// debounced high/low alarms.
module glycemic_index_monitor
    import glycemic_pkg::*;
#(
    parameter int SENSOR_W = DEF_SENSOR_W,
    parameter int GI_W     = DEF_GI_W,
    parameter int WIN_LOG2 = DEF_WIN_LOG2,
    parameter int HI_TH    = DEF_HI_TH,
    parameter int LO_TH    = DEF_LO_TH,
    parameter int HYST     = DEF_HYST,
    parameter int CONFIRM  = DEF_CONFIRM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SENSOR_W-1:0] bloodSensor,
    input  logic                sample_valid,
    input  logic                flush,
    output logic [GI_W-1:0]     glycemicIndex,
    output logic [SENSOR_W-1:0] gi_avg,
    output logic                gi_valid,
    output logic                hi_alarm,
    output logic                lo_alarm
);

    localparam int ACC_W = SENSOR_W + WIN_LOG2;

    gi_state_t           r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [SENSOR_W-1:0] r_avg;
    logic [GI_W-1:0]     r_gi;
    logic                r_valid;

    logic                w_accept;
    logic                w_last;
    logic [ACC_W-1:0]    w_sum;
    logic [SENSOR_W-1:0] w_avg;
    logic [GI_W-1:0]     w_gi;

    assign w_accept = sample_valid && !flush;
    assign w_last   = w_accept && (r_cnt == '1);
    assign w_sum    = r_acc + ACC_W'(bloodSensor);
    assign w_avg    = w_sum[ACC_W-1:WIN_LOG2];
    assign w_gi     = w_avg[SENSOR_W-1 -: GI_W];

    // The accumulator restarts from zero on window completion, so a sample
    // accepted in REPORT opens the next window without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_avg   <= '0;
            r_gi    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (flush) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= IDLE;
            end else if (w_accept) begin
                r_cnt <= r_cnt + WIN_LOG2'(1);
                if (w_last) begin
                    r_acc   <= '0;
                    r_avg   <= w_avg;
                    r_gi    <= w_gi;
                    r_valid <= 1'b1;
                    r_state <= REPORT;
                end else begin
                    r_acc   <= w_sum;
                    r_state <= ACCUM;
                end
            end else if (r_state == REPORT) begin
                r_state <= IDLE;
            end
        end
    end

    gi_alarm_tracker #(
        .DIR     (DIR_HIGH),
        .GI_W    (GI_W),
        .TH      (HI_TH),
        .HYST    (HYST),
        .CONFIRM (CONFIRM)
    ) u_hi (
        .clk      (clk),
        .rst      (rst),
        .i_update (w_last),
        .i_index  (w_gi),
        .o_alarm  (hi_alarm)
    );

    gi_alarm_tracker #(
        .DIR     (DIR_LOW),
        .GI_W    (GI_W),
        .TH      (LO_TH),
        .HYST    (HYST),
        .CONFIRM (CONFIRM)
    ) u_lo (
        .clk      (clk),
        .rst      (rst),
        .i_update (w_last),
        .i_index  (w_gi),
        .o_alarm  (lo_alarm)
    );

    assign glycemicIndex = r_gi;
    assign gi_avg        = r_avg;
    assign gi_valid      = r_valid;

endmodule

// File: tb/tb_glycemic_index_monitor.sv
// Bench for glycemic_index_monitor: directed scenarios plus random traffic,
// all compared against a window/queue reference model.
module tb_glycemic_index_monitor;

    localparam int WIN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bloodSensor;
    logic       sample_valid;
    logic       flush;
    logic [3:0] glycemicIndex;
    logic [7:0] gi_avg;
    logic       gi_valid;
    logic       hi_alarm;
    logic       lo_alarm;

    int n_vec = 0;
    int n_err = 0;

    int         win_q[$];
    logic [7:0] m_avg;
    logic [3:0] m_gi;
    logic       m_valid;
    logic       m_hi;
    logic       m_lo;
    int         hi_run;
    int         lo_run;

    glycemic_index_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .bloodSensor   (bloodSensor),
        .sample_valid  (sample_valid),
        .flush         (flush),
        .glycemicIndex (glycemicIndex),
        .gi_avg        (gi_avg),
        .gi_valid      (gi_valid),
        .hi_alarm      (hi_alarm),
        .lo_alarm      (lo_alarm)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge pass, then advance the model.
    task automatic step(input logic r, input logic v, input logic f, input logic [7:0] s);
        int sum;
        int idx;
        rst = r; sample_valid = v; flush = f; bloodSensor = s;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        if (r) begin
            win_q.delete();
            m_avg = 0; m_gi = 0; m_hi = 0; m_lo = 0; hi_run = 0; lo_run = 0;
        end else if (f) begin
            win_q.delete();
        end else if (v) begin
            win_q.push_back(int'(s));
            if (win_q.size() == WIN) begin
                sum = 0;
                foreach (win_q[k]) sum += win_q[k];
                m_avg   = 8'(sum / WIN);
                idx     = (sum / WIN) / 16;
                m_gi    = 4'(idx);
                m_valid = 1'b1;
                if (idx >= 12) begin
                    hi_run++;
                    if (hi_run >= 2) m_hi = 1'b1;
                end else begin
                    hi_run = 0;
                    if (idx < 11) m_hi = 1'b0;
                end
                if (idx <= 3) begin
                    lo_run++;
                    if (lo_run >= 2) m_lo = 1'b1;
                end else begin
                    lo_run = 0;
                    if (idx > 4) m_lo = 1'b0;
                end
                win_q.delete();
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
        n_vec++;
        if ({gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm} !== 15'h0) begin
            n_err++;
            $display("FAIL reset: got %h expected %h", {gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm}, 15'h0);
        end
    endtask

    task automatic test_window_avg();
        logic [7:0] vals [4];
        int pulses;
        vals = '{8'hAA, 8'h12, 8'h9F, 8'h71};
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(1'b0, 1'b1, 1'b0, vals[i]);
            else       step(1'b0, 1'b0, 1'b0, 8'h00);
            if (gi_valid) pulses++;
            n_vec++;
            if ({gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm} !== {m_valid, m_gi, m_avg, m_hi, m_lo}) begin
                n_err++;
                $display("FAIL window_avg cyc%0d: got v=%b gi=%0d avg=%h hi=%b lo=%b expected v=%b gi=%0d avg=%h hi=%b lo=%b",
                         i, gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm, m_valid, m_gi, m_avg, m_hi, m_lo);
            end
            if (i == 3) begin
                n_vec++;
                if ({gi_valid, gi_avg, glycemicIndex, hi_alarm, lo_alarm} !== {1'b1, 8'h73, 4'd7, 2'b00}) begin
                    n_err++;
                    $display("FAIL window_avg_value: got v=%b avg=%h gi=%0d hi=%b lo=%b expected v=1 avg=73 gi=7 hi=0 lo=0",
                             gi_valid, gi_avg, glycemicIndex, hi_alarm, lo_alarm);
                end
            end
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL window_avg_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_high_alarm();
        logic [7:0] vals [4];
        logic [3:0] idx [4];
        logic       hi [4];
        vals = '{8'hFF, 8'hFF, 8'hB0, 8'hA0};
        idx  = '{4'd15, 4'd15, 4'd11, 4'd10};
        hi   = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < WIN; k++) begin
                step(1'b0, 1'b1, 1'b0, vals[w]);
                n_vec++;
                if ({gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm} !== {m_valid, m_gi, m_avg, m_hi, m_lo}) begin
                    n_err++;
                    $display("FAIL high_alarm w%0d s%0d: got v=%b gi=%0d avg=%h hi=%b lo=%b expected v=%b gi=%0d avg=%h hi=%b lo=%b",
                             w, k, gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm, m_valid, m_gi, m_avg, m_hi, m_lo);
                end
            end
            n_vec++;
            if ({gi_valid, glycemicIndex, hi_alarm} !== {1'b1, idx[w], hi[w]}) begin
                n_err++;
                $display("FAIL high_alarm_window%0d: got v=%b gi=%0d hi=%b expected v=1 gi=%0d hi=%b",
                         w, gi_valid, glycemicIndex, hi_alarm, idx[w], hi[w]);
            end
        end
    endtask

    task automatic test_low_alarm();
        logic [7:0] vals [3];
        logic       lo [3];
        vals = '{8'h20, 8'h20, 8'h50};
        lo   = '{1'b0, 1'b1, 1'b0};
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < WIN; k++) begin
                step(1'b0, 1'b1, 1'b0, vals[w]);
                n_vec++;
                if ({gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm} !== {m_valid, m_gi, m_avg, m_hi, m_lo}) begin
                    n_err++;
                    $display("FAIL low_alarm w%0d s%0d: got v=%b gi=%0d avg=%h hi=%b lo=%b expected v=%b gi=%0d avg=%h hi=%b lo=%b",
                             w, k, gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm, m_valid, m_gi, m_avg, m_hi, m_lo);
                end
            end
            n_vec++;
            if ({gi_valid, lo_alarm} !== {1'b1, lo[w]}) begin
                n_err++;
                $display("FAIL low_alarm_window%0d: got v=%b lo=%b expected v=1 lo=%b", w, gi_valid, lo_alarm, lo[w]);
            end
        end
    endtask

    task automatic test_flush();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 2)       step(1'b0, 1'b1, 1'b0, 8'hFF);
            else if (i == 2) step(1'b0, 1'b1, 1'b1, 8'hFF);
            else             step(1'b0, 1'b1, 1'b0, 8'h10);
            if (gi_valid) pulses++;
            n_vec++;
            if ({gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm} !== {m_valid, m_gi, m_avg, m_hi, m_lo}) begin
                n_err++;
                $display("FAIL flush cyc%0d: got v=%b gi=%0d avg=%h hi=%b lo=%b expected v=%b gi=%0d avg=%h hi=%b lo=%b",
                         i, gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm, m_valid, m_gi, m_avg, m_hi, m_lo);
            end
        end
        n_vec++;
        if ({pulses, glycemicIndex, gi_avg} !== {32'd1, 4'd1, 8'h10}) begin
            n_err++;
            $display("FAIL flush_result: got pulses=%0d gi=%0d avg=%h expected pulses=1 gi=1 avg=10", pulses, glycemicIndex, gi_avg);
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int pulses;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_vec++;
        if ({gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm} !== 15'h0) begin
            n_err++;
            $display("FAIL midwindow_reset: got %h expected %h", {gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm}, 15'h0);
        end
        first = -1; second = -1; pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, (i < 8), 1'b0, 8'h80);
            if (gi_valid) begin
                pulses++;
                if (first < 0) first = i; else second = i;
                n_vec++;
                if (glycemicIndex !== 4'd8) begin
                    n_err++;
                    $display("FAIL back_to_back_index cyc%0d: got %0d expected 8", i, glycemicIndex);
                end
            end
            n_vec++;
            if ({gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm} !== {m_valid, m_gi, m_avg, m_hi, m_lo}) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got v=%b gi=%0d avg=%h expected v=%b gi=%0d avg=%h",
                         i, gi_valid, glycemicIndex, gi_avg, m_valid, m_gi, m_avg);
            end
        end
        n_vec++;
        if (pulses != 2 || second - first != 4) begin
            n_err++;
            $display("FAIL back_to_back_spacing: got pulses=%0d gap=%0d expected pulses=2 gap=4", pulses, second - first);
        end
    endtask

    task automatic test_random();
        int level;
        logic r, v, f;
        logic [7:0] s;
        level = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 12 == 0) level = int'($urandom_range(0, 2));
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            case (level)
                0:       s = 8'($urandom_range(0, 8'h3F));
                1:       s = 8'($urandom_range(8'hC0, 8'hFF));
                default: s = 8'($urandom_range(0, 8'hFF));
            endcase
            step(r, v, f, s);
            n_vec++;
            if ({gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm} !== {m_valid, m_gi, m_avg, m_hi, m_lo}) begin
                n_err++;
                $display("FAIL random cyc%0d: got v=%b gi=%0d avg=%h hi=%b lo=%b expected v=%b gi=%0d avg=%h hi=%b lo=%b",
                         i, gi_valid, glycemicIndex, gi_avg, hi_alarm, lo_alarm, m_valid, m_gi, m_avg, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sample_valid = 1'b0; flush = 1'b0; bloodSensor = 8'h00;
        m_avg = 0; m_gi = 0; m_valid = 0; m_hi = 0; m_lo = 0; hi_run = 0; lo_run = 0;
        test_reset();
        test_window_avg();
        test_high_alarm();
        test_low_alarm();
        test_flush();
        test_back_to_back();
        test_random();
        step(1'b0, 1'b0, 1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
